// File: rtl/varredura_matriz_if.sv
// varredura_matriz_if: row-write handshake and commit request between the pattern loader and the scan controller
// master (loader): drives carga_valida, carga_linha, carga_dados, troca; reads carga_pronta
// slave (controller): reads the request fields; drives carga_pronta
interface varredura_matriz_if #(parameter int COLS = 5);
  logic carga_valida, carga_pronta, troca;
  logic [2:0] carga_linha;
  logic [COLS-1:0] carga_dados;
  modport master (output carga_valida, carga_linha, carga_dados, troca, input carga_pronta);
  modport slave (input carga_valida, carga_linha, carga_dados, troca, output carga_pronta);
endinterface

// File: rtl/varredura_matriz.sv
// varredura_matriz: 7-row LED matrix scan controller with shadow/active column buffers committed at frame boundaries
// clock, reset (async, active-high); habilita: 1 = scan, 0 = idle (code 000 selects the 7-segment path)
// carga: write handshake (slave) into the shadow buffer plus troca commit request
// CH2..CH0: row code; valido: 1 = rows blanked; colunas: active bits of current row; fim_quadro: frame-boundary pulse
// MATRIZ_BRILHO_EN: adds brilho[2:0], shortening the lit part of each row slot
module varredura_matriz #(parameter int DWELL = 1000, parameter int COLS = 5) (
  input logic clock,
  input logic reset,
  input logic habilita,
`ifdef MATRIZ_BRILHO_EN
  input logic [2:0] brilho,
`endif
  varredura_matriz_if.slave carga,
  output logic CH2,
  output logic CH1,
  output logic CH0,
  output logic valido,
  output logic [COLS-1:0] colunas,
  output logic fim_quadro
);
  localparam int CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {OCIOSO, APAGA, ACENDE} estado_t;
  estado_t estado;
  logic [2:0] linha, linha_nx;
  logic [CW-1:0] cnt, lim, lim_nx;
  logic [COLS-1:0] sombra [1:7], ativo [1:7], sombra_nx [1:7];
  logic grava, fim_linha, quadro, copia;
  assign grava = carga.carga_valida && carga.carga_pronta;
  assign fim_linha = estado == ACENDE && cnt == CW'(DWELL - 1);
  assign quadro = fim_linha && linha == 3'd7;
  assign linha_nx = (estado == OCIOSO || linha == 3'd7) ? 3'd1 : linha + 3'd1;
  // a pending commit waits for the frame boundary; when idle there is no frame to protect
  assign copia = (estado == OCIOSO && (carga.troca || !carga.carga_pronta)) || (quadro && habilita && !carga.carga_pronta);
`ifdef MATRIZ_BRILHO_EN
  assign lim_nx = CW'(1 + ((int'(brilho) + 1) * (DWELL - 1)) / 8);
`else
  assign lim_nx = CW'(DWELL);
`endif
  // shadow as it will be after this edge, so a same-cycle write lands in the committed copy
  always_comb begin
    for (int i = 1; i <= 7; i++) sombra_nx[i] = (grava && carga.carga_linha == 3'(i)) ? carga.carga_dados : sombra[i];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      linha <= '0;
      cnt <= '0;
      lim <= '0;
      {CH2, CH1, CH0} <= 3'd0;
      valido <= 1'b1;
      colunas <= '0;
      fim_quadro <= 1'b0;
      carga.carga_pronta <= 1'b1;
      for (int i = 1; i <= 7; i++) begin
        sombra[i] <= '0;
        ativo[i] <= '0;
      end
    end else begin
      sombra <= sombra_nx;
      if (copia) ativo <= sombra_nx;
      carga.carga_pronta <= copia || (carga.carga_pronta && !carga.troca);
      fim_quadro <= habilita && quadro;
      if (!habilita) begin
        estado <= OCIOSO;
        linha <= '0;
        cnt <= '0;
        {CH2, CH1, CH0} <= 3'd0;
        valido <= 1'b1;
        colunas <= '0;
      end else if (estado == OCIOSO || fim_linha) begin
        estado <= APAGA;
        linha <= linha_nx;
        cnt <= '0;
        {CH2, CH1, CH0} <= linha_nx;
        valido <= 1'b1;
        colunas <= copia ? sombra_nx[linha_nx] : ativo[linha_nx];
      end else begin
        if (estado == APAGA) lim <= lim_nx;
        estado <= ACENDE;
        cnt <= cnt + CW'(1);
        // brightness limit is latched during APAGA so it cannot change mid-slot
        valido <= (cnt + CW'(1)) >= (estado == APAGA ? lim_nx : lim);
      end
    end
  end
endmodule
